// File: rtl/uart1_frame_pkg.sv
// Shared constants and state encoding for the UART1 frame parser.
// Frame = 4-byte header, 4-byte version/num field, then NUM_PULSE 8-byte records.
package uart1_frame_pkg;

    localparam logic [31:0] HEAD_DEF      = 32'h7FFF7FFF;
    localparam int          NUM_PULSE_DEF = 12;
    localparam int          HDR_BYTES     = 4;
    localparam int          REC_BYTES     = 8;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        HDR  = 2'd1,
        REC  = 2'd2
    } state_e;

endpackage

// File: rtl/uart1_hdr_hunt.sv
// Sliding 32-bit header detector; bytes enter at the top so the
// first received byte ends up as the least-significant byte.
module uart1_hdr_hunt
    import uart1_frame_pkg::*;
#(
    parameter logic [31:0] HEAD = HEAD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_i,
    input  logic       vld,
    input  logic       clr,
    output logic       match
);

    logic [31:0] sr_q;
    logic [31:0] sr_d;
    logic [31:0] sr_next;

    assign sr_next = {byte_i, sr_q[31:8]};
    assign match   = vld && (sr_next == HEAD);

    always_comb begin
        sr_d = sr_q;
        if (vld) begin
            sr_d = sr_next;
        end
        if (clr) begin
            sr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/rx_parse_uart1.sv
// UART1 frame parser: pulls bytes from an RX FIFO and emits decoded records.
// Optional inter-byte timeout is built only when RX_TIMEOUT_EN is defined.
module rx_parse_uart1
    import uart1_frame_pkg::*;
#(
    parameter logic [31:0] HEAD        = HEAD_DEF,
    parameter int          NUM_PULSE   = NUM_PULSE_DEF,
    parameter int          TIMEOUT_CYC = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    output logic        rx_fifo_ren,
    input  logic [7:0]  rx_fifo_rdata,
    input  logic        rx_fifo_empty,
    output logic [15:0] frame_version,
    output logic        rec_valid,
    output logic [7:0]  rec_index,
    output logic [23:0] rec_width,
    output logic [31:0] rec_period,
    output logic        frame_done,
    output logic        err_num,
    output logic        err_index,
    output logic        err_timeout
);

    state_e      state_q, state_d;
    logic        byte_vld_q;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  rec_cnt_q, rec_cnt_d;
    logic [7:0]  ver_lo_q, ver_lo_d;
    logic [7:0]  num_lo_q, num_lo_d;
    logic [7:0]  idx_q, idx_d;
    logic [23:0] width_q, width_d;
    logic [31:0] period_q, period_d;
    logic [15:0] frame_version_q, frame_version_d;
    logic        rec_valid_q, rec_valid_d;
    logic [7:0]  rec_index_q, rec_index_d;
    logic [23:0] rec_width_q, rec_width_d;
    logic [31:0] rec_period_q, rec_period_d;
    logic        frame_done_q, frame_done_d;
    logic        err_num_q, err_num_d;
    logic        err_index_q, err_index_d;
    logic        err_timeout_q, err_timeout_d;
    logic        hdr_match;

`ifdef RX_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`else
    logic        unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

    assign rx_fifo_ren = ena && !rx_fifo_empty;

    uart1_hdr_hunt #(
        .HEAD   (HEAD)
    ) u_hunt (
        .clk    (clk),
        .rst    (rst),
        .byte_i (rx_fifo_rdata),
        .vld    (byte_vld_q && (state_q == HUNT)),
        .clr    (hdr_match),
        .match  (hdr_match)
    );

    always_comb begin
        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        rec_cnt_d       = rec_cnt_q;
        ver_lo_d        = ver_lo_q;
        num_lo_d        = num_lo_q;
        idx_d           = idx_q;
        width_d         = width_q;
        period_d        = period_q;
        frame_version_d = frame_version_q;
        rec_index_d     = rec_index_q;
        rec_width_d     = rec_width_q;
        rec_period_d    = rec_period_q;
        rec_valid_d     = 1'b0;
        frame_done_d    = 1'b0;
        err_num_d       = 1'b0;
        err_index_d     = 1'b0;
        err_timeout_d   = 1'b0;
`ifdef RX_TIMEOUT_EN
        tmo_d           = tmo_q;
`endif

        if (byte_vld_q) begin
            unique case (state_q)
                HUNT: begin
                    if (hdr_match) begin
                        state_d    = HDR;
                        byte_cnt_d = '0;
                    end
                end
                HDR: begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    case (byte_cnt_q)
                        3'd0: ver_lo_d = rx_fifo_rdata;
                        3'd1: frame_version_d = {rx_fifo_rdata, ver_lo_q};
                        3'd2: num_lo_d = rx_fifo_rdata;
                        default: begin
                            byte_cnt_d = '0;
                            if ({rx_fifo_rdata, num_lo_q} == 16'(NUM_PULSE)) begin
                                state_d   = REC;
                                rec_cnt_d = '0;
                            end else begin
                                state_d   = HUNT;
                                err_num_d = 1'b1;
                            end
                        end
                    endcase
                end
                REC: begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd0) begin
                        if (rx_fifo_rdata == rec_cnt_q) begin
                            idx_d = rx_fifo_rdata;
                        end else begin
                            state_d     = HUNT;
                            byte_cnt_d  = '0;
                            err_index_d = 1'b1;
                        end
                    end else if (byte_cnt_q < 3'd4) begin
                        width_d = {rx_fifo_rdata, width_q[23:8]};
                    end else if (byte_cnt_q != 3'(REC_BYTES - 1)) begin
                        period_d = {rx_fifo_rdata, period_q[31:8]};
                    end else begin
                        // Last byte goes straight to the output register.
                        period_d     = {rx_fifo_rdata, period_q[31:8]};
                        rec_valid_d  = 1'b1;
                        rec_index_d  = idx_q;
                        rec_width_d  = width_q;
                        rec_period_d = {rx_fifo_rdata, period_q[31:8]};
                        rec_cnt_d    = rec_cnt_q + 8'd1;
                        if (rec_cnt_q == 8'(NUM_PULSE - 1)) begin
                            frame_done_d = 1'b1;
                            state_d      = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

`ifdef RX_TIMEOUT_EN
        // A byte in this cycle clears the timer, so content errors always win.
        if (byte_vld_q) begin
            tmo_d = '0;
        end else if (state_q != HUNT) begin
            if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
                err_timeout_d = 1'b1;
                state_d       = HUNT;
                tmo_d         = '0;
                byte_cnt_d    = '0;
                rec_cnt_d     = '0;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= HUNT;
            byte_vld_q      <= 1'b0;
            byte_cnt_q      <= '0;
            rec_cnt_q       <= '0;
            ver_lo_q        <= '0;
            num_lo_q        <= '0;
            idx_q           <= '0;
            width_q         <= '0;
            period_q        <= '0;
            frame_version_q <= '0;
            rec_valid_q     <= 1'b0;
            rec_index_q     <= '0;
            rec_width_q     <= '0;
            rec_period_q    <= '0;
            frame_done_q    <= 1'b0;
            err_num_q       <= 1'b0;
            err_index_q     <= 1'b0;
            err_timeout_q   <= 1'b0;
`ifdef RX_TIMEOUT_EN
            tmo_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            byte_vld_q      <= rx_fifo_ren;
            byte_cnt_q      <= byte_cnt_d;
            rec_cnt_q       <= rec_cnt_d;
            ver_lo_q        <= ver_lo_d;
            num_lo_q        <= num_lo_d;
            idx_q           <= idx_d;
            width_q         <= width_d;
            period_q        <= period_d;
            frame_version_q <= frame_version_d;
            rec_valid_q     <= rec_valid_d;
            rec_index_q     <= rec_index_d;
            rec_width_q     <= rec_width_d;
            rec_period_q    <= rec_period_d;
            frame_done_q    <= frame_done_d;
            err_num_q       <= err_num_d;
            err_index_q     <= err_index_d;
            err_timeout_q   <= err_timeout_d;
`ifdef RX_TIMEOUT_EN
            tmo_q           <= tmo_d;
`endif
        end
    end

    assign frame_version = frame_version_q;
    assign rec_valid     = rec_valid_q;
    assign rec_index     = rec_index_q;
    assign rec_width     = rec_width_q;
    assign rec_period    = rec_period_q;
    assign frame_done    = frame_done_q;
    assign err_num       = err_num_q;
    assign err_index     = err_index_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: doc/rx_parse_uart1.md
RX_PARSE_UART1 -- requirements
Module: rx_parse_uart1

Interface
REQ-001 Parameter HEAD, default 32'h7FFF7FFF: frame header word, received least-significant byte first.
REQ-002 Parameter NUM_PULSE, default 12: expected record count per frame.
REQ-003 Parameter TIMEOUT_CYC, default 500000: inter-byte timeout in clk cycles; used only with RX_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ena  in  1  parser enable; gates FIFO reads only.
REQ-007 rx_fifo_ren  out  1  RX FIFO read strobe.
REQ-008 rx_fifo_rdata  in  8  FIFO data, valid the cycle after rx_fifo_ren.
REQ-009 rx_fifo_empty  in  1  FIFO empty flag.
REQ-010 frame_version  out  16  version field of the current frame.
REQ-011 rec_valid  out  1  one-cycle strobe; the rec_* outputs are valid.
REQ-012 rec_index  out  8  record index byte.
REQ-013 rec_width  out  24  pulse width, bytes 1..3 of the record, LSB first.
REQ-014 rec_period  out  32  pulse period, bytes 4..7 of the record, LSB first.
REQ-015 frame_done  out  1  one-cycle strobe after the last record of a good frame.
REQ-016 err_num  out  1  one-cycle strobe; the num field is not equal to NUM_PULSE.
REQ-017 err_index  out  1  one-cycle strobe; the record index is out of sequence.
REQ-018 err_timeout  out  1  one-cycle strobe on inter-byte timeout.

Function
REQ-019 rx_fifo_ren SHALL be ena && !rx_fifo_empty; it is combinational, with no other gating.
REQ-020 byte_vld SHALL be rx_fifo_ren registered once; the parser consumes rx_fifo_rdata only when byte_vld=1.
REQ-021 FSM states SHALL be HUNT, HDR, REC; the reset state is HUNT.
REQ-022 HUNT: each valid byte SHALL shift into a 32-bit register as {byte, sr[31:8]}; sr==HEAD moves the FSM to HDR, clears byte_cnt, and clears sr.
REQ-023 HDR: four bytes SHALL be consumed (version LSB, version MSB, num LSB, num MSB); frame_version updates when version MSB arrives.
REQ-024 On num MSB: num==NUM_PULSE moves the FSM to REC with rec_cnt=0; otherwise err_num pulses and the FSM returns to HUNT.
REQ-025 REC, byte 0 (index): index==rec_cnt continues the record; otherwise err_index pulses and the FSM returns to HUNT with that byte discarded.
REQ-026 REC, bytes 1..7: the width and period shift registers SHALL be filled; byte_cnt is a 3-bit counter that wraps 7->0.
REQ-027 On byte 7: rec_valid and the rec_* outputs SHALL be registered the following cycle (latency 1 from the byte_vld of byte 7), and rec_cnt increments.
REQ-028 When rec_cnt reaches NUM_PULSE-1 at byte 7: frame_done SHALL pulse in the same cycle as the final rec_valid, and the FSM returns to HUNT.
REQ-029 Header bytes inside HDR or REC SHALL be treated as data; re-synchronisation happens only through HUNT.
REQ-030 Deasserting ena mid-frame SHALL hold all state; an in-flight byte (byte_vld) is still consumed.
REQ-031 Simultaneous events (error and timeout in the same cycle): the error from byte content SHALL take priority; only one strobe fires.

Reset
REQ-032 rst=1 SHALL set the FSM to HUNT and clear sr, byte_cnt, rec_cnt, byte_vld, and the timeout counter.
REQ-033 rst=1 SHALL drive all outputs to 0, including during a read in flight; the byte delivered after reset is discarded.

Configuration
REQ-034 With macro RX_TIMEOUT_EN defined: a counter SHALL clear on every byte_vld and increment while the FSM is not in HUNT.
REQ-035 With RX_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYC-1, err_timeout pulses, the FSM returns to HUNT, and the counters clear.
REQ-036 With RX_TIMEOUT_EN undefined: no counter is built, and err_timeout is tied to 0; the port is still present.

Structure
REQ-037 Package uart1_frame_pkg SHALL hold the HEAD default, the NUM_PULSE default, HDR_BYTES=4, REC_BYTES=8, and the FSM state enum.
REQ-038 Sub-module uart1_hdr_hunt SHALL implement the sliding header detector (byte in, vld, clr, match out).

Verification
REQ-039 Good frame: send FF 7F FF 7F, 00 00, 0C 00, then 12 records {i, width=i+1, period=0x100*i} -> 12 rec_valid strobes with matching values, and frame_done in the same cycle as the 12th.
REQ-040 Garbage resync: 3 junk bytes, then FF 7F FF FF 7F FF 7F, then a good frame -> the header is found at the correct alignment and 12 records are decoded.
REQ-041 Bad count: num=0x000B -> err_num=1 for one cycle, no rec_valid; the next good frame decodes normally.
REQ-042 Index skip: the record indices run 0,1,3 -> err_index pulses at the third record's index byte, and only 2 rec_valid strobes occur.
REQ-043 Empty FIFO / ena low for 20 cycles mid-record -> rx_fifo_ren=0 throughout, no state loss, and the record completes after resume.
REQ-044 RX_TIMEOUT_EN with TIMEOUT_CYC=16: stall 16 cycles inside REC -> err_timeout pulses once and the FSM is in HUNT; without the macro, the same stall gives no strobe.
